pc_stack: RTL



---
 rtl/pc_stack.sv | 117 +++++++++++
 1 files changed

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
//  Module   : pc_stack
//  Purpose  : NISC program counter with branches and a return-address stack.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_stack #(
    parameter int Psize  = 4,
    parameter int Osize  = 4,
    parameter int Sdepth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hold,
    input  logic [2:0]                   op,
    input  logic                         flag,
    input  logic [Psize-1:0]             target,
    input  logic [Osize-1:0]             offset,
    output logic [Psize-1:0]             out,
    output logic [$clog2(Sdepth+1)-1:0]  depth,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int DW = $clog2(Sdepth + 1);
    localparam int IW = (Sdepth > 1) ? $clog2(Sdepth) : 1;

    localparam logic [2:0] c_op_inc    = 3'd0;
    localparam logic [2:0] c_op_jmp    = 3'd1;
    localparam logic [2:0] c_op_jrel   = 3'd2;
    localparam logic [2:0] c_op_brt    = 3'd3;
    localparam logic [2:0] c_op_brtrel = 3'd4;
    localparam logic [2:0] c_op_call   = 3'd5;
    localparam logic [2:0] c_op_ret    = 3'd6;

    localparam logic [DW-1:0] c_full = DW'(Sdepth);

    logic [Psize-1:0] out_q, out_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [Psize-1:0] stack_q [Sdepth];
    logic [Psize-1:0] stack_d [Sdepth];

    logic [Psize-1:0] pc_inc;
    logic [Psize-1:0] pc_rel;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    pop_idx;

    // Offset is sign-extended by the size cast of a signed operand.
    assign pc_inc   = out_q + Psize'(1);
    assign pc_rel   = out_q + Psize'($signed(offset));
    assign push_idx = IW'(depth_q);
    assign pop_idx  = IW'(depth_q - DW'(1));

    always_comb begin
        out_d       = out_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        stack_d     = stack_q;
        if (!hold) begin
            out_d = pc_inc;
            case (op)
                c_op_jmp:    out_d = target;
                c_op_jrel:   out_d = pc_rel;
                c_op_brt:    if (flag) out_d = target;
                c_op_brtrel: if (flag) out_d = pc_rel;
                c_op_call: begin
                    if (depth_q != c_full) begin
                        stack_d[push_idx] = pc_inc;
                        depth_d           = depth_q + DW'(1);
                        out_d             = target;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                c_op_ret: begin
                    if (depth_q != '0) begin
                        out_d   = stack_q[pop_idx];
                        depth_d = depth_q - DW'(1);
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                c_op_inc: ;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack entries carry no reset; depth alone defines which are valid.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign out       = out_q;
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
`default_nettype wire
